busca_instrucao: RTL

Instruction fetch controller that sequences the program ROM. It holds the program counter, drives the ROM read address, and registers each instruction word into a one-entry output stage with a valid/ready handshake toward the decoder. It also handles jumps (desvio), address wrap-around and the halt opcode. It sits between the ROM and the control/decode unit and is the only master of the ROM address bus.

---
 rtl/busca_instrucao_if.sv | 31 +++
 rtl/busca_instrucao.sv | 123 ++++++++++++
 2 files changed

// File: rtl/busca_instrucao_if.sv
// Fetch-unit bus: ROM read port, decoder valid/ready handshake and status outputs.
// master = fetch controller side, slave = ROM/decoder/environment side.
interface busca_instrucao_if #(
  parameter int LARGURA_END   = 8,
  parameter int LARGURA_INSTR = 8
);
  logic                     iniciar;
  logic                     desvio_valido;
  logic [LARGURA_END-1:0]   desvio_endereco;
  logic [LARGURA_END-1:0]   endereco_rom;
  logic [LARGURA_INSTR-1:0] instrucao_rom;
  logic [LARGURA_INSTR-1:0] instrucao_out;
  logic [LARGURA_END-1:0]   pc_out;
  logic                     instrucao_valida;
  logic                     instrucao_pronta;
  logic                     parado;
  logic                     erro_desvio;
  logic [15:0]              contador_instr;

  modport master (
    input  iniciar, desvio_valido, desvio_endereco, instrucao_rom, instrucao_pronta,
    output endereco_rom, instrucao_out, pc_out, instrucao_valida, parado,
           erro_desvio, contador_instr
  );

  modport slave (
    output iniciar, desvio_valido, desvio_endereco, instrucao_rom, instrucao_pronta,
    input  endereco_rom, instrucao_out, pc_out, instrucao_valida, parado,
           erro_desvio, contador_instr
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch controller: owns the PC, reads the ROM combinationally and
// registers each word into a one-entry valid/ready slot; handles jumps, wrap and halt.
module busca_instrucao #(
  parameter int                    LARGURA_END   = 8,
  parameter int                    LARGURA_INSTR = 8,
  parameter int                    END_INICIAL   = 0,
  parameter int                    END_FINAL     = 31,
  parameter logic [LARGURA_INSTR-1:0] OPCODE_PARADA = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  busca_instrucao_if.master bus
);

  localparam logic [LARGURA_END-1:0] INICIO = LARGURA_END'(END_INICIAL);
  localparam logic [LARGURA_END-1:0] FIM    = LARGURA_END'(END_FINAL);
  localparam logic [LARGURA_END-1:0] UM     = LARGURA_END'(1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_t;

  estado_t                  estado_q, estado_d;
  logic [LARGURA_END-1:0]   pc_q, pc_d;
  logic [LARGURA_INSTR-1:0] instr_q, instr_d;
  logic [LARGURA_END-1:0]   pc_out_q, pc_out_d;
  logic                     valida_q, valida_d;
  logic                     parado_q, parado_d;
  logic                     erro_q, erro_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     aceite;

  assign aceite = valida_q && bus.instrucao_pronta;

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valida_d = valida_q;
    parado_d = parado_q;
    erro_d   = 1'b0;
    cnt_d    = (aceite && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    case (estado_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          estado_d = BUSCA;
          pc_d     = INICIO;
        end
      end
      BUSCA: begin
        if (bus.desvio_valido) begin
          // A jump flushes the slot even if the decoder never took the word.
          valida_d = 1'b0;
          if (bus.desvio_endereco > FIM) begin
            pc_d   = INICIO;
            erro_d = 1'b1;
          end else begin
            pc_d = bus.desvio_endereco;
          end
        end else if (!valida_q || bus.instrucao_pronta) begin
          instr_d  = bus.instrucao_rom;
          pc_out_d = pc_q;
          valida_d = 1'b1;
          pc_d     = (pc_q == FIM) ? INICIO : pc_q + UM;
          if (bus.instrucao_rom == OPCODE_PARADA) begin
            estado_d = PARADO;
            parado_d = 1'b1;
          end
        end
      end
      PARADO: begin
        if (bus.iniciar) begin
          estado_d = BUSCA;
          parado_d = 1'b0;
          pc_d     = INICIO;
          valida_d = 1'b0;
        end else if (aceite) begin
          valida_d = 1'b0;
        end
      end
      default: begin
        estado_d = OCIOSO;
        parado_d = 1'b0;
        valida_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      pc_q     <= INICIO;
      instr_q  <= '0;
      pc_out_q <= '0;
      valida_q <= 1'b0;
      parado_q <= 1'b0;
      erro_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valida_q <= valida_d;
      parado_q <= parado_d;
      erro_q   <= erro_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.endereco_rom     = pc_q;
  assign bus.instrucao_out    = instr_q;
  assign bus.pc_out           = pc_out_q;
  assign bus.instrucao_valida = valida_q;
  assign bus.parado           = parado_q;
  assign bus.erro_desvio      = erro_q;
  assign bus.contador_instr   = cnt_q;

endmodule
